fb_pixel_sink: RTL and testbench

Framebuffer-side endpoint of the pixel plot interface driven by the team's shape-drawing FSMs (circle, Reuleaux). Accepts one `plot`/`x`/`y`/`colour` strobe per cycle with no backpressure. Clips and writes each pixel into an internal 160x120x3 framebuffer. Also provides a fill (clear) engine and a raster-order scan-out port, so benches and downstream blocks can read back what the drawing FSMs produced.

---
 rtl/fb_pixel_sink.sv | 193 +++++++++++++++++++
 tb/tb_fb_pixel_sink.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_sink.sv
// Framebuffer endpoint for the pixel plot interface: clipped single-cycle plots into a
// WIDTH x HEIGHT x CW single-port RAM, plus a fill engine and a raster-order scan-out port.
module fb_pixel_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          plot,
    input  logic [7:0]    x,
    input  logic [6:0]    y,
    input  logic [CW-1:0] colour,
    input  logic          clear_start,
    input  logic [CW-1:0] clear_colour,
    input  logic          scan_start,
    output logic          busy,
    output logic          scan_valid,
    output logic [7:0]    scan_x,
    output logic [6:0]    scan_y,
    output logic [CW-1:0] scan_colour,
    output logic          scan_done,
    output logic [15:0]   plot_count,
    output logic [15:0]   drop_count
);

    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
    localparam logic [7:0]  LAST_COL  = 8'(WIDTH - 1);
    localparam logic [8:0]  X_LIM     = 9'(WIDTH);
    localparam logic [7:0]  Y_LIM     = 8'(HEIGHT);

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN, SCAN_LAST} state_e;

    state_e          state_q, state_d;
    logic [14:0]     addr_q, addr_d;
    logic [7:0]      col_q, col_d;
    logic [6:0]      row_q, row_d;
    logic [CW-1:0]   fill_q, fill_d;

    logic [CW-1:0]   mem [DEPTH];
    logic            ram_we;
    logic            rd_en;
    logic            rd_last;
    logic [14:0]     ram_addr;
    logic [CW-1:0]   ram_wdata;

    logic [CW-1:0]   rd_data_q;
    logic            rd_valid_q;
    logic            rd_last_q;
    logic [7:0]      px_q;
    logic [6:0]      py_q;
    logic [15:0]     plot_cnt_q;
    logic [15:0]     drop_cnt_q;

    logic            in_range;
    logic            plot_acc;
    logic            plot_drop;
    logic [14:0]     plot_addr;

    assign in_range  = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    assign plot_acc  = plot && in_range && (state_q != CLEAR);
    assign plot_drop = plot && !plot_acc;
    assign plot_addr = 15'(y) * 15'(WIDTH) + 15'(x);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        addr_d    = addr_q;
        col_d     = col_q;
        row_d     = row_q;
        fill_d    = fill_q;
        ram_we    = 1'b0;
        ram_addr  = plot_addr;
        ram_wdata = colour;
        rd_en     = 1'b0;
        rd_last   = 1'b0;

        case (state_q)
            IDLE: begin
                ram_we = plot_acc;
                if (clear_start) begin
                    state_d = CLEAR;
                    fill_d  = clear_colour;
                    addr_d  = '0;
                end else if (scan_start) begin
                    state_d = SCAN;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = fill_q;
                addr_d    = addr_q + 15'd1;
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            end
            SCAN: begin
                // An accepted plot owns the single RAM port; the scan stalls for that cycle.
                if (plot_acc) begin
                    ram_we = 1'b1;
                end else begin
                    rd_en    = 1'b1;
                    ram_addr = addr_q;
                    addr_d   = addr_q + 15'd1;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + 7'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                    if (addr_q == LAST_ADDR) begin
                        state_d = SCAN_LAST;
                        rd_last = 1'b1;
                        addr_d  = '0;
                        col_d   = '0;
                        row_d   = '0;
                    end
                end
            end
            SCAN_LAST: begin
                ram_we  = plot_acc;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the framebuffer array has no reset; a reset cycle only suppresses the write.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[ram_addr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            fill_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            plot_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            fill_q     <= fill_d;
            rd_valid_q <= rd_en;
            rd_last_q  <= rd_last;
            if (rd_en) begin
                px_q <= col_q;
                py_q <= row_q;
            end
            if (plot_acc && plot_cnt_q != 16'hFFFF) begin
                plot_cnt_q <= plot_cnt_q + 16'd1;
            end
            if (plot_drop && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign scan_valid  = rd_valid_q;
    assign scan_x      = px_q;
    assign scan_y      = py_q;
    assign scan_colour = rd_data_q;
    assign scan_done   = rd_valid_q && rd_last_q;
    assign plot_count  = plot_cnt_q;
    assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Bench for fb_pixel_sink: a full 160x120 instance for the clear/scan timing, and a
// 20x16 instance for plot, clip, collision, fill-interlock and reset sequences.
module tb_fb_pixel_sink;

    localparam int SW = 20;
    localparam int SH = 16;
    localparam int SN = SW * SH;
    localparam int FW = 160;
    localparam int FH = 120;
    localparam int FN = FW * FH;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       clear_start;
    logic [2:0] clear_colour;
    logic       scan_start;

    logic        busy, scan_valid, scan_done;
    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    logic [2:0]  scan_colour;
    logic [15:0] plot_count, drop_count;

    logic        f_plot;
    logic        f_clear_start, f_scan_start;
    logic        f_busy, f_scan_valid, f_scan_done;
    logic [7:0]  f_scan_x;
    logic [6:0]  f_scan_y;
    logic [2:0]  f_scan_colour;
    logic [15:0] f_plot_count, f_drop_count;

    fb_pixel_sink #(.WIDTH(SW), .HEIGHT(SH), .CW(3)) dut (
        .clk(clk), .rst(rst), .plot(plot), .x(x), .y(y), .colour(colour),
        .clear_start(clear_start), .clear_colour(clear_colour), .scan_start(scan_start),
        .busy(busy), .scan_valid(scan_valid), .scan_x(scan_x), .scan_y(scan_y),
        .scan_colour(scan_colour), .scan_done(scan_done),
        .plot_count(plot_count), .drop_count(drop_count)
    );

    fb_pixel_sink dut_full (
        .clk(clk), .rst(rst), .plot(f_plot), .x(x), .y(y), .colour(colour),
        .clear_start(f_clear_start), .clear_colour(clear_colour), .scan_start(f_scan_start),
        .busy(f_busy), .scan_valid(f_scan_valid), .scan_x(f_scan_x), .scan_y(f_scan_y),
        .scan_colour(f_scan_colour), .scan_done(f_scan_done),
        .plot_count(f_plot_count), .drop_count(f_drop_count)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [2:0] exp_img [SN];

    typedef struct {
        logic        pl;
        logic [7:0]  vx;
        logic [6:0]  vy;
        logic [2:0]  vc;
        logic [15:0] e_plot;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Small-instance fill; optionally pokes a plot and scan_start while it runs.
    task automatic run_clear(input logic [2:0] c, input bit extras, input string tag);
        int len;
        len = 0;
        clear_colour = c;
        clear_start  = 1'b1;
        scan_start   = extras;
        @(negedge clk);
        clear_start  = 1'b0;
        scan_start   = 1'b0;
        for (int t = 0; t < SN + 50; t++) begin
            if (!busy) break;
            len++;
            plot       = 1'b0;
            scan_start = 1'b0;
            if (extras && len == 10) begin
                plot = 1'b1; x = 8'd5; y = 7'd5; colour = 3'd3;
                scan_start = 1'b1;
            end
            @(negedge clk);
        end
        plot       = 1'b0;
        scan_start = 1'b0;
        check({tag, " busy cycles"}, len, SN);
        @(negedge clk);
        check({tag, " idle after fill"}, busy, 0);
        for (int i = 0; i < SN; i++) exp_img[i] = c;
    endtask

    // Small-instance scan against exp_img; optionally plots (2,12) and (2,0) mid-scan.
    task automatic run_scan(input bit inject, input string tag);
        int nvalid, busy_len, first_valid, pos_err, col_err, done_err, first_bad;
        bit ended, inj0, inj1;
        nvalid = 0; busy_len = 0; first_valid = 0; pos_err = 0; col_err = 0;
        done_err = 0; first_bad = -1; ended = 0; inj0 = 0; inj1 = 0;
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        for (int t = 1; t <= SN + 50; t++) begin
            if (scan_valid) begin
                if (first_valid == 0) first_valid = t;
                if (nvalid < SN) begin
                    if (scan_x !== 8'(nvalid % SW) || scan_y !== 7'(nvalid / SW)) pos_err++;
                    if (scan_colour !== exp_img[nvalid]) begin
                        col_err++;
                        if (first_bad < 0) first_bad = nvalid;
                    end
                end
                if (scan_done !== (nvalid == SN - 1)) done_err++;
                nvalid++;
            end else if (scan_done !== 1'b0) begin
                done_err++;
            end
            if (!busy) begin
                ended = 1;
                break;
            end
            busy_len++;
            plot = 1'b0;
            if (inject && !inj0 && nvalid == 7 * SW) begin
                plot = 1'b1; x = 8'd2; y = 7'd12; colour = 3'd6;
                inj0 = 1;
                exp_img[12 * SW + 2] = 3'd6;
            end else if (inject && inj0 && !inj1) begin
                plot = 1'b1; x = 8'd2; y = 7'd0; colour = 3'd6;
                inj1 = 1;
            end
            @(negedge clk);
        end
        plot = 1'b0;
        check({tag, " scan ended"}, ended, 1);
        check({tag, " pixel count"}, nvalid, SN);
        check({tag, " first valid obs"}, first_valid, 2);
        check({tag, " busy cycles"}, busy_len, inject ? SN + 3 : SN + 1);
        check({tag, " raster position errors"}, pos_err, 0);
        check($sformatf("%s colour errors (first idx %0d)", tag, first_bad), col_err, 0);
        check({tag, " scan_done placement errors"}, done_err, 0);
        if (inject) exp_img[2] = 3'd6;
    endtask

    initial begin
        int len, nvalid, pos_err, col_err, done_err, first_valid;

        vecs[0] = '{1'b1, 8'd0,   7'd0,   3'd5, 16'd1, 16'd0};
        vecs[1] = '{1'b1, 8'd19,  7'd15,  3'd7, 16'd2, 16'd0};
        vecs[2] = '{1'b1, 8'd10,  7'd8,   3'd1, 16'd3, 16'd0};
        vecs[3] = '{1'b1, 8'd20,  7'd0,   3'd7, 16'd3, 16'd1};
        vecs[4] = '{1'b1, 8'd0,   7'd16,  3'd7, 16'd3, 16'd2};
        vecs[5] = '{1'b1, 8'd255, 7'd127, 3'd7, 16'd3, 16'd3};
        vecs[6] = '{1'b0, 8'd3,   7'd3,   3'd4, 16'd3, 16'd3};

        rst = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
        clear_start = 1'b0; clear_colour = '0; scan_start = 1'b0;
        f_plot = 1'b0; f_clear_start = 1'b0; f_scan_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset busy", busy, 0);
        check("reset scan_valid", scan_valid, 0);
        check("reset scan_done", scan_done, 0);
        check("reset scan_xy", {scan_x, scan_y}, 0);
        check("reset scan_colour", scan_colour, 0);
        check("reset plot_count", plot_count, 0);
        check("reset drop_count", drop_count, 0);
        check("reset full counts", {f_plot_count, f_drop_count}, 0);

        // Full-size fill to colour 2 and scan-out.
        clear_colour  = 3'd2;
        f_clear_start = 1'b1;
        @(negedge clk);
        f_clear_start = 1'b0;
        len = 0;
        for (int t = 0; t < FN + 100; t++) begin
            if (!f_busy) break;
            len++;
            @(negedge clk);
        end
        check("full clear busy cycles", len, FN);

        f_scan_start = 1'b1;
        @(negedge clk);
        f_scan_start = 1'b0;
        len = 0; nvalid = 0; pos_err = 0; col_err = 0; done_err = 0; first_valid = 0;
        for (int t = 1; t <= FN + 100; t++) begin
            if (f_scan_valid) begin
                if (first_valid == 0) first_valid = t;
                if (f_scan_x !== 8'(nvalid % FW) || f_scan_y !== 7'(nvalid / FW)) pos_err++;
                if (f_scan_colour !== 3'd2) col_err++;
                if (f_scan_done !== (nvalid == FN - 1)) done_err++;
                nvalid++;
            end else if (f_scan_done !== 1'b0) begin
                done_err++;
            end
            if (!f_busy) break;
            len++;
            @(negedge clk);
        end
        check("full scan pixel count", nvalid, FN);
        check("full scan first valid obs", first_valid, 2);
        check("full scan busy cycles", len, FN + 1);
        check("full scan raster errors", pos_err, 0);
        check("full scan colour errors", col_err, 0);
        check("full scan done errors", done_err, 0);

        // Small instance: fill to 0, then table of plots (three hits, three clips, one idle).
        run_clear(3'd0, 1'b0, "clear0");
        for (int i = 0; i < 7; i++) begin
            plot = vecs[i].pl; x = vecs[i].vx; y = vecs[i].vy; colour = vecs[i].vc;
            if (vecs[i].pl && int'(vecs[i].vx) < SW && int'(vecs[i].vy) < SH)
                exp_img[int'(vecs[i].vy) * SW + int'(vecs[i].vx)] = vecs[i].vc;
            @(negedge clk);
            check($sformatf("vec%0d plot_count", i), plot_count, vecs[i].e_plot);
            check($sformatf("vec%0d drop_count", i), drop_count, vecs[i].e_drop);
        end
        plot = 1'b0;
        run_scan(1'b0, "scan_plots");

        // Collision: one plot ahead of the scan pointer, one behind it.
        run_scan(1'b1, "scan_collide");
        check("collide plot_count", plot_count, 5);
        run_scan(1'b0, "scan_after_collide");

        // Fill with simultaneous scan_start, plus a plot and scan_start mid-fill.
        run_clear(3'd4, 1'b1, "clear_interlock");
        check("interlock drop_count", drop_count, 4);
        check("interlock plot_count", plot_count, 5);
        run_scan(1'b0, "scan_interlock");

        // Reset on the fill cycle that would write address 100.
        clear_colour = 3'd1;
        clear_start  = 1'b1;
        @(negedge clk);
        clear_start  = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy", busy, 0);
        check("midreset scan_valid", scan_valid, 0);
        check("midreset counts", {plot_count, drop_count}, 0);
        for (int i = 0; i < 100; i++) exp_img[i] = 3'd1;
        @(negedge clk);
        check("midreset stays idle", busy, 0);
        run_scan(1'b0, "scan_midreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
